// File: rtl/base2log_pkg.sv
// ---------------------------------------------------------------------------
// base2log_pkg
// Purpose : shared widths and the fractional lookup table used by the base-2
//           logarithm approximator (result is unsigned Q5.3).
// Contents: INPUT_WIDTH, OUTPUT_WIDTH, FRAC_BITS, LOG_LUT and lut_frac().
// ---------------------------------------------------------------------------
package base2log_pkg;

   localparam int INPUT_WIDTH  = 32;
   localparam int OUTPUT_WIDTH = 8;
   localparam int FRAC_BITS    = 3;

   // round(8*log2(1+idx/16)) for idx = 0..15; entry 15 reaches 8 (a full
   // integer step), so each entry is 4 bits wide.
   localparam logic [3:0] LOG_LUT [16] = '{
      4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
      4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8
   };

   function automatic logic [3:0] lut_frac(input logic [3:0] idx);
      return LOG_LUT[idx];
   endfunction

endpackage

// File: rtl/base2log_if.sv
// ---------------------------------------------------------------------------
// base2log_if
// Purpose : groups the operand/result signals of base2log.
// Signals : valid_i, number_i (toward the block); valid_o, log_o (from it).
// Modports: master = producer of operands, slave = the base2log block.
// ---------------------------------------------------------------------------
interface base2log_if
   import base2log_pkg::*;
#(
   parameter int IW = INPUT_WIDTH,
   parameter int OW = OUTPUT_WIDTH
);
   logic          valid_i;
   logic [IW-1:0] number_i;
   logic          valid_o;
   logic [OW-1:0] log_o;

   modport master (output valid_i, output number_i, input valid_o, input log_o);
   modport slave  (input valid_i, input number_i, output valid_o, output log_o);
endinterface

// File: rtl/base2log_lod32.sv
// ---------------------------------------------------------------------------
// lod32
// Purpose : combinational leading-one detector for a 32-bit word.
// Ports   : i_data [31:0] word to scan
//           o_pos  [4:0]  index of the most significant set bit (0 if none)
//           o_zero        high when i_data has no set bit
// ---------------------------------------------------------------------------
module lod32 (
   input  logic [31:0] i_data,
   output logic [4:0]  o_pos,
   output logic        o_zero
);

   // Ascending scan: the highest set bit is the last one to write the result.
   function automatic logic [4:0] lod_index(input logic [31:0] data);
      logic [4:0] pos;
      pos = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (data[i]) begin
            pos = 5'(i);
         end else begin
            pos = pos;
         end
      end
      return pos;
   endfunction

   assign o_pos  = lod_index(i_data);
   assign o_zero = (i_data == 32'd0);

endmodule

// File: rtl/base2log.sv
// ---------------------------------------------------------------------------
// base2log
// Purpose : one-cycle-latency approximate log2 of an unsigned 32-bit operand,
//           unsigned Q5.3 result saturating at 255.
// Ports   : clk  - sole clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - base2log_if.slave (valid_i, number_i in; valid_o, log_o out)
// ---------------------------------------------------------------------------
module base2log
   import base2log_pkg::*;
#(
   parameter int INPUT_WIDTH  = base2log_pkg::INPUT_WIDTH,
   parameter int OUTPUT_WIDTH = base2log_pkg::OUTPUT_WIDTH,
   parameter int FRAC_BITS    = base2log_pkg::FRAC_BITS
) (
   input  logic       clk,
   input  logic       rst,
   base2log_if.slave  bus
);

   localparam int RAW_W = OUTPUT_WIDTH + 1;

   logic [4:0]              w_pos;
   logic                    w_zero;
   logic [4:0]              w_shift;
   logic [INPUT_WIDTH-1:0]  w_norm;
   logic [3:0]              w_idx;
   logic [3:0]              w_frac;
   logic [RAW_W-1:0]        w_raw;
   logic [OUTPUT_WIDTH-1:0] w_result;

   logic                    r_valid;
   logic [OUTPUT_WIDTH-1:0] r_log;

   lod32 u_lod (
      .i_data (bus.number_i),
      .o_pos  (w_pos),
      .o_zero (w_zero)
   );

   // Normalise so the leading one sits at the MSB; the next four bits are the
   // LUT index. Zeros shifted in model the positions below bit 0.
   assign w_shift = 5'd31 - w_pos;
   assign w_norm  = bus.number_i << w_shift;
   assign w_idx   = 4'(w_norm >> (INPUT_WIDTH - 5));
   assign w_frac  = lut_frac(w_idx);

   // 9-bit sum so 8*31 + 8 = 256 is visible to the saturation step.
   assign w_raw = (RAW_W'(w_pos) << FRAC_BITS) + RAW_W'(w_frac);

   // Saturate and force the all-zero operand to a zero result.
   always_comb begin
      w_result = {OUTPUT_WIDTH{1'b0}};
      if (w_zero) begin
         w_result = {OUTPUT_WIDTH{1'b0}};
      end else if (w_raw > RAW_W'({OUTPUT_WIDTH{1'b1}})) begin
         w_result = {OUTPUT_WIDTH{1'b1}};
      end else begin
         w_result = w_raw[OUTPUT_WIDTH-1:0];
      end
   end

   // Single output stage: result is captured only on valid samples, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_log   <= {OUTPUT_WIDTH{1'b0}};
      end else begin
         r_valid <= bus.valid_i;
         if (bus.valid_i) begin
            r_log <= w_result;
         end else begin
            r_log <= r_log;
         end
      end
   end

   assign bus.valid_o = r_valid;
   assign bus.log_o   = r_log;

endmodule

// File: tb/tb_base2log.sv
// ---------------------------------------------------------------------------
// tb_base2log
// Purpose : self-checking bench for base2log: directed vector table, reset
//           sequences and a random sweep against an independent model.
// ---------------------------------------------------------------------------
module tb_base2log;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   base2log_if bus ();

   base2log dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] number;
      logic        exp_valid;
      logic [7:0]  exp_log;
   } vec_t;

   vec_t vecs [$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: written bit-by-bit, independent of the RTL structure.
   function automatic int ref_log(input logic [31:0] x);
      int lut [16];
      int p;
      int idx;
      int raw;
      lut = '{0, 1, 1, 2, 3, 3, 4, 4, 5, 5, 6, 6, 6, 7, 7, 8};
      if (x == 32'd0) return 0;
      p = 0;
      for (int b = 31; b >= 0; b--) begin
         if (x[b]) begin
            p = b;
            break;
         end
      end
      idx = 0;
      for (int k = 1; k <= 4; k++) begin
         idx = idx * 2;
         if (p - k >= 0) idx = idx + int'(x[p-k]);
      end
      raw = 8 * p + lut[idx];
      return (raw > 255) ? 255 : raw;
   endfunction

   task automatic add(input logic v, input logic [31:0] n, input logic ev, input logic [7:0] el);
      vec_t t;
      t.valid = v; t.number = n; t.exp_valid = ev; t.exp_log = el;
      vecs.push_back(t);
   endtask

   initial begin
      logic [31:0] x;
      int          got;
      real         err;
      n_checks = 0;
      n_fail   = 0;
      rst          = 1'b1;
      bus.valid_i  = 1'b0;
      bus.number_i = 32'd0;
      step();
      step();
      check("reset_valid", int'(bus.valid_o), 0);
      check("reset_log", int'(bus.log_o), 0);
      rst = 1'b0;

      // Directed table: applied on consecutive cycles, checked one edge later.
      add(1'b1, 32'd0,          1'b1, 8'd0);
      add(1'b1, 32'd1,          1'b1, 8'd0);
      add(1'b1, 32'd2,          1'b1, 8'd8);
      add(1'b1, 32'd3,          1'b1, 8'd13);
      add(1'b1, 32'd1000,       1'b1, 8'd80);
      add(1'b1, 32'h8000_0000,  1'b1, 8'd248);
      add(1'b1, 32'hFFFF_FFFF,  1'b1, 8'd255);
      add(1'b1, 32'd7,          1'b1, 8'd22);
      add(1'b1, 32'h10,         1'b1, 8'd32);
      add(1'b1, 32'h18,         1'b1, 8'd37);
      add(1'b1, 32'd5,          1'b1, 8'd19);
      add(1'b0, 32'd7,          1'b0, 8'd19);
      add(1'b0, 32'd1000,       1'b0, 8'd19);
      add(1'b0, 32'hFFFF_FFFF,  1'b0, 8'd19);
      add(1'b1, 32'hFFFF,       1'b1, 8'd128);

      foreach (vecs[i]) begin
         bus.valid_i  = vecs[i].valid;
         bus.number_i = vecs[i].number;
         step();
         check($sformatf("vec%0d_valid", i), int'(bus.valid_o), int'(vecs[i].exp_valid));
         check($sformatf("vec%0d_log", i), int'(bus.log_o), int'(vecs[i].exp_log));
      end

      // Valid sample coincident with reset is discarded.
      bus.valid_i  = 1'b1;
      bus.number_i = 32'hFFFF;
      rst = 1'b1;
      step();
      check("rst_hit_valid", int'(bus.valid_o), 0);
      check("rst_hit_log", int'(bus.log_o), 0);
      rst = 1'b0;
      bus.valid_i = 1'b0;
      step();
      check("rst_drop_valid", int'(bus.valid_o), 0);
      check("rst_drop_log", int'(bus.log_o), 0);
      bus.valid_i  = 1'b1;
      bus.number_i = 32'hFFFF;
      step();
      check("post_rst_valid", int'(bus.valid_o), 1);
      check("post_rst_log", int'(bus.log_o), 128);

      // Reset mid-stream drops the pending result.
      bus.number_i = 32'd5;
      step();
      check("stream_log", int'(bus.log_o), 19);
      bus.number_i = 32'd1000;
      rst = 1'b1;
      step();
      check("mid_rst_valid", int'(bus.valid_o), 0);
      check("mid_rst_log", int'(bus.log_o), 0);
      rst = 1'b0;
      bus.valid_i = 1'b0;
      step();
      check("mid_rel_valid", int'(bus.valid_o), 0);
      check("mid_rel_log", int'(bus.log_o), 0);
      bus.valid_i  = 1'b1;
      bus.number_i = 32'd3;
      step();
      check("resume_log", int'(bus.log_o), 13);

      // Random sweep, back-to-back, with magnitudes spread over all bit positions.
      for (int i = 0; i < 10000; i++) begin
         x = $urandom() >> $urandom_range(0, 31);
         bus.valid_i  = 1'b1;
         bus.number_i = x;
         step();
         got = int'(bus.log_o);
         n_checks++;
         if (got != ref_log(x) || bus.valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep x=%0h: got %0d valid %0b expected %0d valid 1",
                     x, got, bus.valid_o, ref_log(x));
         end
         if (x != 32'd0) begin
            err = real'(got) / 8.0 - $ln(real'(x)) / $ln(2.0);
            if (err < 0.0) err = -err;
            n_checks++;
            if (err > 0.125 + 1.0e-9) begin
               n_fail++;
               $display("FAIL sweep_err x=%0h: log %0d error %f allowed 0.125", x, got, err);
            end
         end
      end
      bus.valid_i = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/base2log.md
BASE2LOG -- requirements
Module: base2log

Interface
REQ-001 Parameter INPUT_WIDTH, default 32, input operand width; only 32 need be supported.
REQ-002 Parameter OUTPUT_WIDTH, default 8, result width, Q5.3 format.
REQ-003 Parameter FRAC_BITS, default 3, fractional bits of log_o.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 valid_i  input  1  number_i is valid this cycle.
REQ-007 number_i  input  INPUT_WIDTH  unsigned operand.
REQ-008 valid_o  output  1  log_o is updated this cycle.
REQ-009 log_o  output  OUTPUT_WIDTH  approximate log2(number_i), unsigned Q5.3, saturating.

Function
REQ-010 Latency is exactly 1 cycle: a sample taken with valid_i=1 at edge N appears on log_o, with valid_o=1, after edge N.
REQ-011 valid_o equals valid_i registered; there is no backpressure, and back-to-back valid_i gives one result per cycle.
REQ-012 With valid_i=0, log_o holds its last value and valid_o=0.
REQ-013 Let p = index of the most significant set bit of number_i (0..31).
REQ-014 Let idx = the 4 bits directly below bit p, taken MSB-first; positions below bit 0 read as 0.
REQ-015 frac = LUT[idx], where LUT = round(8*log2(1+idx/16)) = {0,1,1,2,3,3,4,4,5,5,6,6,6,7,7,8}.
REQ-016 Raw result = 8*p + frac, a 9-bit unsigned sum; no truncation before the saturation step.
REQ-017 If the raw result is greater than 255, log_o = 255 (saturate); otherwise log_o = raw result.
REQ-018 number_i = 0 gives log_o = 0; number_i = 1 also gives 0.
REQ-019 All arithmetic is unsigned; number_i is never interpreted as signed.
REQ-020 Result is a pure function of the sampled number_i; there is no dependence on earlier samples.

Reset
REQ-021 While rst=1 at a rising edge: log_o <= 0 and valid_o <= 0, regardless of valid_i.
REQ-022 A valid_i sample coincident with rst=1 is discarded; there is no output for it after rst deasserts.
REQ-023 Reset asserted mid-stream drops any pending result; operation resumes on the first valid_i after rst=0.

Structure
REQ-024 Shared package base2log_pkg holds INPUT_WIDTH, OUTPUT_WIDTH, FRAC_BITS and the 16-entry LUT constant.
REQ-025 One sub-module, lod32: combinational leading-one detector giving p (5 bits) and a zero flag for a 32-bit input.
REQ-026 Mantissa extraction, LUT lookup, add and saturation are combinational in base2log, with a single output register stage.

Verification
REQ-027 number_i=0, 1, 2 on consecutive valid cycles -> log_o = 0, 0, 8 on the following three cycles, valid_o=1 each.
REQ-028 number_i=3 -> log_o=13; number_i=1000 -> log_o=80.
REQ-029 number_i=0x80000000 -> 248; number_i=0xFFFFFFFF -> 255 (saturated).
REQ-030 valid_i pulse with 5, then valid_i=0 for 3 cycles with number_i changing -> log_o=19 held, valid_o=0 after the first cycle.
REQ-031 rst=1 while valid_i=1 with number_i=0xFFFF -> log_o=0, valid_o=0; the next valid sample after release is processed normally.
REQ-032 Random sweep of 10k values against a reference model of REQ-013..REQ-017 -> exact match, and |log_o/8 - log2(x)| <= 0.125 for x >= 1.
